if_fetch_ctrl: RTL

Fetch-request sequencer between the pre-IF PC generator and the instruction SRAM-like port. It accepts the next PC from pre-IF, holds the request stable until the memory accepts it, and tracks the outstanding access. It discards responses made stale by a branch/exception redirect and buffers the fetched instruction until ID can take it. It also drives the allowin back to pre-IF.

---
 rtl/if_fetch_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: sequences instruction fetches between pre-IF and the
// SRAM-like instruction port. It holds each request stable until addr_ok and
// tracks the access in flight. Responses made stale by a redirect are
// discarded, and the fetched word is buffered until ID takes it.
// Ports:
//   clk, reset (sync, active-high).
//   pf_valid/pf_pc/pf_ready carry the next PC from pre-IF.
//   redirect/redirect_pc is a one-cycle redirect to a new PC.
//   inst_sram_* is the request/response port to instruction memory.
//   if_valid/if_pc/if_inst/id_allowin carry the buffered instruction to ID.
//   perf_fetch_cnt/perf_cancel_cnt are counters, built only with
//   IF_FETCH_CTRL_PERF_EN. Without it both read 0.
module if_fetch_ctrl #(
  parameter int CANCEL_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pf_valid,
  input  logic [31:0] pf_pc,
  output logic        pf_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_allowin,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_cancel_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  localparam logic [CANCEL_W-1:0] CNT_MAX = '1;
  localparam logic [CANCEL_W-1:0] CNT_ONE = 1;

  state_e              state_q, state_d;
  logic                rbuf_v_q, rbuf_v_d;
  logic [31:0]         rbuf_pc_q, rbuf_pc_d;
  logic                stale_q, stale_d;
  logic [CANCEL_W-1:0] cnt_q, cnt_d;
  logic [31:0]         if_pc_q, if_pc_d;
  logic [31:0]         if_inst_q, if_inst_d;
  logic [31:0]         req_pc_q, req_pc_d;
  logic                req_pf_q, req_pf_d;

  logic                old_dok;
  logic                cnt_inc;

  // A data_ok while older cancelled accesses remain belongs to one of them.
  assign old_dok = inst_sram_data_ok & (cnt_q != '0);

  always_comb begin
    state_d        = state_q;
    rbuf_v_d       = rbuf_v_q;
    rbuf_pc_d      = rbuf_pc_q;
    stale_d        = stale_q;
    if_pc_d        = if_pc_q;
    if_inst_d      = if_inst_q;
    req_pc_d       = req_pc_q;
    req_pf_d       = req_pf_q;
    cnt_inc        = 1'b0;
    inst_sram_req  = 1'b0;
    inst_sram_addr = req_pc_q;
    pf_ready       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        inst_sram_addr = rbuf_v_q ? rbuf_pc_q : pf_pc;
        inst_sram_req  = (rbuf_v_q | pf_valid) & ~redirect
                       & (cnt_q != CNT_MAX);
        if (inst_sram_req) begin
          // The request now owns the redirect target, so rbuf is freed.
          req_pc_d = inst_sram_addr;
          req_pf_d = ~rbuf_v_q;
          rbuf_v_d = 1'b0;
          if (inst_sram_addr_ok) begin
            state_d  = S_WAIT;
            if_pc_d  = inst_sram_addr;
            pf_ready = ~rbuf_v_q;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        inst_sram_req = 1'b1;
        if (redirect) stale_d = 1'b1;
        if (inst_sram_addr_ok) begin
          pf_ready = req_pf_q;
          stale_d  = 1'b0;
          if (stale_q | redirect) begin
            cnt_inc = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
            if_pc_d = req_pc_q;
          end
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok & (cnt_q == '0)) begin
          if (redirect) begin
            state_d = S_IDLE;
          end else begin
            if_inst_d = inst_sram_rdata;
            state_d   = S_HOLD;
          end
        end else if (redirect) begin
          cnt_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (redirect | id_allowin) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      rbuf_v_d  = 1'b1;
      rbuf_pc_d = redirect_pc;
    end

    cnt_d = cnt_q;
    if (cnt_inc & ~old_dok) cnt_d = cnt_q + CNT_ONE;
    if (~cnt_inc & old_dok) cnt_d = cnt_q - CNT_ONE;

    if (reset) begin
      inst_sram_req = 1'b0;
      pf_ready      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rbuf_v_q  <= 1'b0;
      rbuf_pc_q <= '0;
      stale_q   <= 1'b0;
      cnt_q     <= '0;
      if_pc_q   <= '0;
      if_inst_q <= '0;
      req_pc_q  <= '0;
      req_pf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rbuf_v_q  <= rbuf_v_d;
      rbuf_pc_q <= rbuf_pc_d;
      stale_q   <= stale_d;
      cnt_q     <= cnt_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      req_pc_q  <= req_pc_d;
      req_pf_q  <= req_pf_d;
    end
  end

  assign if_valid = (state_q == S_HOLD);
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;

`ifdef IF_FETCH_CTRL_PERF_EN
  logic [31:0] pfetch_q, pfetch_d;
  logic [31:0] pcancel_q, pcancel_d;
  logic        drop;

  // The current access's own data is dropped when a redirect hits it.
  assign drop = old_dok
              | ((state_q == S_WAIT) & inst_sram_data_ok
                 & (cnt_q == '0) & redirect);

  always_comb begin
    pfetch_d  = pfetch_q;
    pcancel_d = pcancel_q;
    if (if_valid & id_allowin) pfetch_d = pfetch_q + 32'd1;
    if (drop) pcancel_d = pcancel_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pfetch_q  <= '0;
      pcancel_q <= '0;
    end else begin
      pfetch_q  <= pfetch_d;
      pcancel_q <= pcancel_d;
    end
  end

  assign perf_fetch_cnt  = pfetch_q;
  assign perf_cancel_cnt = pcancel_q;
`else
  assign perf_fetch_cnt  = '0;
  assign perf_cancel_cnt = '0;
`endif

endmodule
